// File: rtl/key_schedule.sv
// key_schedule: sequential AES-128 key expansion with an 11-entry round-key store and registered read port.
// Optional feature macro: KEY_SCHEDULE_ZEROIZE_EN adds a zeroize input that clears all storage.
module key_schedule (
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_ready,
    output logic         done,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [7:0] RCON [16] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    state_t       state_q;
    logic [3:0]   step_q;
    logic [127:0] rk_q [11];
    logic [127:0] rd_key_q;
    logic         keys_ready_q;
    logic         done_q;
    logic         clr;
    logic [127:0] next_key;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, with 0 mapping to 0) followed by the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] gen_key(input logic [3:0] round, input logic [127:0] k);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] t;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {RCON[round], 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

`ifdef KEY_SCHEDULE_ZEROIZE_EN
    assign clr = !rst_n || zeroize;
`else
    assign clr = !rst_n;
`endif

    assign next_key   = gen_key(step_q, rk_q[step_q]);
    assign key_ready  = (state_q != EXPAND);
    assign busy       = (state_q == EXPAND);
    assign keys_ready = keys_ready_q;
    assign done       = done_q;
    assign rd_key     = rd_key_q;

    // Control FSM, round-key store and registered read port
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            step_q       <= 4'd0;
            keys_ready_q <= 1'b0;
            done_q       <= 1'b0;
            rd_key_q     <= '0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            rd_key_q <= (rd_round <= 4'd10) ? rk_q[rd_round] : '0;
            done_q   <= 1'b0;
            if (state_q == EXPAND) begin
                rk_q[step_q + 4'd1] <= next_key;
                step_q              <= step_q + 4'd1;
                if (step_q == 4'd9) begin
                    state_q      <= READY;
                    keys_ready_q <= 1'b1;
                    done_q       <= 1'b1;
                end
            end else if (key_valid) begin
                rk_q[0]      <= key_in;
                step_q       <= 4'd0;
                keys_ready_q <= 1'b0;
                state_q      <= EXPAND;
            end
        end
    end
endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule: directed self-checking bench for key_schedule (FIPS-197 vectors).
module tb_key_schedule;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_ready;
    logic         done;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    logic         zeroize;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_FIPS2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_SEQ10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    key_schedule dut (
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .busy(busy),
        .keys_ready(keys_ready),
        .done(done),
        .rd_round(rd_round),
        .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [3:0] r, input logic [127:0] exp, input string name);
        rd_round = r;
        tick();
        checks++;
        if (rd_key !== exp) begin
            errors++;
            $display("FAIL %s: rd_key=%h expected %h", name, rd_key, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_valid = 1'b1;
        key_in = K_FIPS;
        rd_round = 4'd0;
        tick();
        tick();
        key_valid = 1'b0;
        rst_n = 1'b1;
        checks++;
        if ({key_ready, busy, keys_ready, done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: ready/busy/keys_ready/done=%b expected 1000", {key_ready, busy, keys_ready, done});
        end
        checks++;
        if (rd_key !== '0) begin
            errors++;
            $display("FAIL reset_rd_key: rd_key=%h expected 0", rd_key);
        end
    endtask

    task automatic test_fips_load();
        int busy_cycles;
        int done_seen;
        busy_cycles = 0;
        done_seen = 0;
        key_in = K_FIPS;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (busy) busy_cycles++;
            if (done) done_seen++;
            tick();
        end
        checks++;
        if (busy_cycles != 10 || done_seen != 0) begin
            errors++;
            $display("FAIL fips_busy: busy_cycles=%0d done_early=%0d expected 10/0", busy_cycles, done_seen);
        end
        checks++;
        if ({done, keys_ready, busy, key_ready} !== 4'b1101) begin
            errors++;
            $display("FAIL fips_done: done/keys_ready/busy/key_ready=%b expected 1101", {done, keys_ready, busy, key_ready});
        end
        tick();
        checks++;
        if (done !== 1'b0 || keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL fips_done_pulse: done=%b keys_ready=%b expected 0/1", done, keys_ready);
        end
        read_check(4'd1, K_FIPS1, "fips_rk1");
        read_check(4'd2, K_FIPS2, "fips_rk2");
        read_check(4'd10, K_FIPS10, "fips_rk10");
        read_check(4'd0, K_FIPS, "fips_rk0");
    endtask

    task automatic test_out_of_range();
        read_check(4'd11, '0, "oor_11");
        read_check(4'd15, '0, "oor_15");
        read_check(4'd10, K_FIPS10, "oor_back_in_range");
    endtask

    task automatic test_reload();
        key_in = K_SEQ;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        checks++;
        if (keys_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_accept: keys_ready=%b busy=%b expected 0/1", keys_ready, busy);
        end
        for (int n = 1; n <= 10; n++) tick();
        checks++;
        if (done !== 1'b1 || keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_done: done=%b keys_ready=%b expected 1/1", done, keys_ready);
        end
        read_check(4'd10, K_SEQ10, "reload_rk10");
        read_check(4'd0, K_SEQ, "reload_rk0");
    endtask

    task automatic test_back_to_back();
        int ready_seen;
        ready_seen = 0;
        key_in = K_FIPS;
        key_valid = 1'b1;
        tick();
        key_in = K_SEQ;
        for (int n = 1; n <= 9; n++) begin
            if (key_ready) ready_seen++;
            tick();
        end
        if (key_ready) ready_seen++;
        checks++;
        if (ready_seen != 0) begin
            errors++;
            $display("FAIL b2b_key_ready: key_ready high %0d cycles during expand, expected 0", ready_seen);
        end
        tick();
        checks++;
        if ({done, keys_ready, key_ready} !== 3'b111) begin
            errors++;
            $display("FAIL b2b_complete: done/keys_ready/key_ready=%b expected 111", {done, keys_ready, key_ready});
        end
        rd_round = 4'd10;
        tick();
        key_valid = 1'b0;
        checks++;
        if (rd_key !== K_FIPS10) begin
            errors++;
            $display("FAIL b2b_orig_rk10: rd_key=%h expected %h", rd_key, K_FIPS10);
        end
        checks++;
        if (busy !== 1'b1 || keys_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b keys_ready=%b expected 1/0", busy, keys_ready);
        end
        for (int n = 1; n <= 10; n++) tick();
        read_check(4'd10, K_SEQ10, "b2b_new_rk10");
    endtask

    task automatic test_reset_mid_expand();
        int done_seen;
        done_seen = 0;
        key_in = K_FIPS;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int n = 1; n <= 5; n++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({keys_ready, key_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL midrst_flags: keys_ready/key_ready/busy=%b expected 010", {keys_ready, key_ready, busy});
        end
        for (int r = 0; r <= 10; r++) begin
            rd_round = 4'(r);
            tick();
            if (done) done_seen++;
            checks++;
            if (rd_key !== '0) begin
                errors++;
                $display("FAIL midrst_rk%0d: rd_key=%h expected 0", r, rd_key);
            end
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midrst_done: done pulses=%0d expected 0", done_seen);
        end
    endtask

`ifdef KEY_SCHEDULE_ZEROIZE_EN
    task automatic test_zeroize();
        key_in = K_FIPS;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int n = 1; n <= 10; n++) tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        checks++;
        if (keys_ready !== 1'b0 || rd_key !== '0) begin
            errors++;
            $display("FAIL zeroize_ready: keys_ready=%b rd_key=%h expected 0/0", keys_ready, rd_key);
        end
        read_check(4'd10, '0, "zeroize_rk10");
        read_check(4'd0, '0, "zeroize_rk0");
        zeroize = 1'b1;
        key_valid = 1'b1;
        tick();
        zeroize = 1'b0;
        key_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_prio: busy=%b expected 0", busy);
        end
        read_check(4'd0, '0, "zeroize_prio_rk0");
    endtask
`endif

    initial begin
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        test_reset();
        test_fips_load();
        test_out_of_range();
        test_reload();
        test_back_to_back();
        test_reset_mid_expand();
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        test_zeroize();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
